mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares a single N:1 data mux among N requesters. Each requester raises a request, is granted exclusive ownership of the mux, and holds it until it signals done. The arbiter drives the mux select and the registered one-hot grant, and forwards the owner's data to the shared output. It sits between the requesting units and the shared downstream consumer.

## Interface
- N, 2, number of requesters (2..8)
- W, 8, data width per requester
- TIMEOUT, 16, maximum grant length in cycles; used only when MUX_ARB_TIMEOUT_EN is defined
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  N  per-requester request level
- done  input  N  per-requester release strobe; only the owner's bit is honoured
- data_in  input  N*W  requester i data at bits [i*W +: W]
- gnt  output  N  registered one-hot grant; all zeros when idle
- sel  output  $clog2(N)  mux select; equals the index of the set gnt bit, 0 when idle
- out_valid  output  1  equals |gnt
- data_out  output  W  data_in slice selected by sel when out_valid is high, else 0
- timeout  output  1  one-cycle pulse on a forced release (tied 0 without the macro)

## Operation
- States: IDLE and GRANT. The state, gnt, sel and last pointer are registered.
- Pick function: scan req starting at index (last+1) mod N, wrap around, and take the first set bit. The current owner is skipped while any other bit is set.
- IDLE:
  - If any req bit is set at the edge, go to GRANT with gnt equal to the picked bit.
  - The last pointer is updated to the granted index.
- GRANT, release condition: done[owner]=1, or req[owner]=0 (drop is treated as done), or a forced timeout.
- GRANT, on release:
  - Re-pick from req at the same edge.
  - If some other requester is set, switch directly to it with no idle cycle.
  - If only the owner is still requesting, re-grant the owner.
  - If no request is set, go to IDLE with gnt=0.
- GRANT, no release: gnt is held. New requests do not pre-empt the owner.
- done bits of non-owners and done in IDLE are ignored.
- data_out is combinational from the registered sel and data_in. There is no data register.

## Timing
- Reset values: gnt=0, sel=0, out_valid=0, data_out=0, timeout=0, state=IDLE, last=N-1. Requester 0 therefore wins first after reset.
- Reset asserted mid-grant: at the next edge all outputs go to their reset values. Pending requests are re-arbitrated from scratch after reset deasserts.
- Grant latency: a req rising before edge k produces gnt at edge k, one cycle later.
- Handover: done sampled at edge k means the new owner's gnt is visible after edge k. There is no dead cycle between owners.
- Simultaneous requests are resolved only by the rotating priority. There are no fixed priorities.
- sel and gnt always change together. gnt never has more than one bit set.

## Configuration
- Macro: MUX_ARB_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT)-bit hold counter clears on every new grant and increments each cycle in GRANT.
  - When it reaches TIMEOUT-1 without a release, the next edge forces a release with the re-pick rules above.
  - timeout pulses high for exactly one cycle after that edge.
  - done and timeout on the same edge count as a normal done; timeout stays 0.
- Not defined: no counter is built, timeout is tied to 0, and a grant lasts until done or a req drop.

## Structure
- Package mux_arb_pkg holds the state enum (ARB_IDLE, ARB_GRANT) and a function that converts a one-hot vector to an index.
- Sub-module rr_pick is combinational. Inputs: req, last, owner, owner_valid. Outputs: pick_onehot, pick_idx, pick_valid.
- The top level holds the FSM, registers, optional counter and data mux.

## Test plan
- Reset, then req=2'b01 with data_in={8'hBB,8'hAA} → one cycle later gnt=01, sel=0, data_out=AA. Then done[0] with req=00 → gnt=00, data_out=00.
- req=2'b11 held with done pulsed every 3 cycles → grants alternate 01,10,01,10 with no idle cycle between owners.
- Owner 0 granted; req[1] rises, no done → gnt stays 01. Then req[0] drops → gnt=10 at the next edge.
- Only requester 1 requests and pulses done while still requesting → re-granted 10 with no gap; sel stays 1.
- Reset asserted during gnt=10 → next cycle gnt=00, out_valid=0. After reset with req=11 → gnt=01.
- With MUX_ARB_TIMEOUT_EN and TIMEOUT=4: req=11, no done → gnt=01 for 4 cycles, then gnt=10 and timeout=1 for one cycle. Without the macro, gnt=01 is held indefinitely and timeout stays 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   // Supports up to 8 requesters; the caller zero-extends narrower vectors.
   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: scan from last+1 with wrap, skipping the
// current owner whenever anyone else is requesting.
module rr_pick
   import mux_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] last,
   input  logic [SW-1:0] owner,
   input  logic          owner_valid,
   output logic [N-1:0]  pick_onehot,
   output logic [SW-1:0] pick_idx,
   output logic          pick_valid
);

   logic [N-1:0] owner_oh;
   logic [N-1:0] others;
   logic [N-1:0] masked;
   int           j;

   always_comb begin
      owner_oh        = '0;
      owner_oh[owner] = owner_valid;
      others          = req & ~owner_oh;
      masked          = (others != '0) ? others : req;
   end

   always_comb begin
      pick_onehot = '0;
      pick_valid  = 1'b0;
      j           = 0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(last) + k) % N;
         if (!pick_valid && masked[j]) begin
            pick_valid     = 1'b1;
            pick_onehot[j] = 1'b1;
         end
      end
   end

   assign pick_idx = SW'(onehot_to_idx(8'(pick_onehot)));

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a shared N:1 data mux.
// Optional forced release after TIMEOUT cycles: define MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int N       = 2,
   parameter int W       = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         done,
   input  logic [N*W-1:0]       data_in,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] sel,
   output logic                 out_valid,
   output logic [W-1:0]         data_out,
   output logic                 timeout
);

   localparam int SW = $clog2(N);

   arb_state_e    state_q;
   logic [N-1:0]  gnt_q;
   logic [SW-1:0] sel_q;
   logic [SW-1:0] last_q;

   logic [N-1:0]  pick_onehot;
   logic [SW-1:0] pick_idx;
   logic          pick_valid;
   logic          owner_valid;
   logic          force_d;
   logic          release_d;
   logic          timeout_d;

   assign owner_valid = (state_q == ARB_GRANT);

   rr_pick #(.N(N), .SW(SW)) u_pick (
      .req         (req),
      .last        (last_q),
      .owner       (sel_q),
      .owner_valid (owner_valid),
      .pick_onehot (pick_onehot),
      .pick_idx    (pick_idx),
      .pick_valid  (pick_valid)
   );

`ifdef MUX_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0] cnt_q;
   logic          timeout_q;

   assign force_d = owner_valid && (cnt_q == CW'(TIMEOUT - 1));
   assign timeout = timeout_q;
`else
   assign force_d = 1'b0;
   assign timeout = 1'b0;
`endif

   // A simultaneous done or req drop wins over the forced release for reporting.
   assign release_d = owner_valid && (done[sel_q] || !req[sel_q] || force_d);
   assign timeout_d = force_d && !done[sel_q] && req[sel_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= SW'(N - 1);
`ifdef MUX_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
`ifdef MUX_ARB_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            ARB_IDLE: begin
               if (pick_valid) begin
                  state_q <= ARB_GRANT;
                  gnt_q   <= pick_onehot;
                  sel_q   <= pick_idx;
                  last_q  <= pick_idx;
`ifdef MUX_ARB_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            ARB_GRANT: begin
               if (release_d) begin
`ifdef MUX_ARB_TIMEOUT_EN
                  timeout_q <= timeout_d;
                  cnt_q     <= '0;
`endif
                  if (pick_valid) begin
                     gnt_q  <= pick_onehot;
                     sel_q  <= pick_idx;
                     last_q <= pick_idx;
                  end else begin
                     state_q <= ARB_IDLE;
                     gnt_q   <= '0;
                     sel_q   <= '0;
                  end
               end else begin
`ifdef MUX_ARB_TIMEOUT_EN
                  cnt_q <= cnt_q + CW'(1);
`endif
               end
            end
            default: begin
               state_q <= ARB_IDLE;
               gnt_q   <= '0;
               sel_q   <= '0;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign out_valid = |gnt_q;
   assign data_out  = out_valid ? data_in[int'(sel_q)*W +: W] : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (N=2, W=8, TIMEOUT=4).
module tb_mux_rr_arbiter;

   localparam int N = 2;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N-1:0]   done;
   logic [N*W-1:0] data_in;
   logic [N-1:0]   gnt;
   logic [0:0]     sel;
   logic           out_valid;
   logic [W-1:0]   data_out;
   logic           timeout;

   int vectors = 0;
   int miscompares = 0;

   mux_rr_arbiter #(.N(N), .W(W), .TIMEOUT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .done      (done),
      .data_in   (data_in),
      .gnt       (gnt),
      .sel       (sel),
      .out_valid (out_valid),
      .data_out  (data_out),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_owner(input string tag, input logic [1:0] exp_gnt);
      logic [7:0] exp_data;
      exp_data = (exp_gnt == 2'b01) ? data_in[7:0] : (exp_gnt == 2'b10) ? data_in[15:8] : 8'h00;
      chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
      chk({tag, ".sel"}, 32'(sel), (exp_gnt == 2'b10) ? 32'd1 : 32'd0);
      chk({tag, ".valid"}, 32'(out_valid), 32'(exp_gnt != 2'b00));
      chk({tag, ".data"}, 32'(data_out), 32'(exp_data));
   endtask

   logic [1:0] alt_exp [4];

   initial begin
      reset   = 1'b1;
      req     = '0;
      done    = '0;
      data_in = {8'hBB, 8'hAA};
      tick();
      tick();
      chk_owner("reset", 2'b00);
      chk("reset.timeout", 32'(timeout), 32'd0);

      // Single request, then release with done.
      reset = 1'b0;
      req   = 2'b01;
      tick();
      chk_owner("single", 2'b01);
      data_in = {8'hBB, 8'h5A};
      #1;
      chk("single.dataflow", 32'(data_out), 32'h5A);
      data_in = {8'hBB, 8'hAA};
      done = 2'b01;
      req  = 2'b00;
      tick();
      done = 2'b00;
      chk_owner("release", 2'b00);

      // done in IDLE is ignored.
      done = 2'b11;
      tick();
      done = 2'b00;
      chk_owner("idle_done", 2'b00);

      // Both requesting, done every 3 cycles; last=0 so requester 1 goes first.
      alt_exp[0] = 2'b10;
      alt_exp[1] = 2'b01;
      alt_exp[2] = 2'b10;
      alt_exp[3] = 2'b01;
      req = 2'b11;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk_owner($sformatf("alt%0d", i), alt_exp[i]);
         tick();
         chk($sformatf("alt%0d.hold", i), 32'(gnt), 32'(alt_exp[i]));
         tick();
         chk($sformatf("alt%0d.hold2", i), 32'(gnt), 32'(alt_exp[i]));
         done = 2'b11;
         tick();
         done = 2'b00;
      end
      chk_owner("alt_end", 2'b10);
      req = 2'b00;
      tick();
      chk_owner("alt_idle", 2'b00);

      // No pre-emption; non-owner done ignored; req drop acts as done.
      req = 2'b01;
      tick();
      chk_owner("nopre.grant", 2'b01);
      req = 2'b11;
      tick();
      chk_owner("nopre.hold", 2'b01);
      done = 2'b10;
      tick();
      done = 2'b00;
      chk_owner("nopre.nonowner_done", 2'b01);
      req = 2'b10;
      tick();
      chk_owner("drop", 2'b10);

      // Sole requester pulses done: re-granted with no gap.
      done = 2'b10;
      tick();
      done = 2'b00;
      chk_owner("regrant", 2'b10);
      tick();
      chk_owner("regrant.hold", 2'b10);

      // Reset mid-grant.
      reset = 1'b1;
      tick();
      chk_owner("midreset", 2'b00);
      chk("midreset.timeout", 32'(timeout), 32'd0);
      reset = 1'b0;
      req   = 2'b11;
      tick();
      chk_owner("postreset", 2'b01);

`ifdef MUX_ARB_TIMEOUT_EN
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("to.hold%0d", i), 32'(gnt), 32'b01);
         chk($sformatf("to.pulse%0d", i), 32'(timeout), 32'd0);
      end
      tick();
      chk_owner("to.switch", 2'b10);
      chk("to.pulse", 32'(timeout), 32'd1);
      tick();
      chk("to.pulse_end", 32'(timeout), 32'd0);
      chk("to.after", 32'(gnt), 32'b10);
      tick();
      tick();
      done = 2'b10;
      tick();
      done = 2'b00;
      chk("to.done_wins", 32'(timeout), 32'd0);
      chk("to.done_gnt", 32'(gnt), 32'b01);
`else
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk($sformatf("nto.hold%0d", i), 32'(gnt), 32'b01);
         chk($sformatf("nto.pulse%0d", i), 32'(timeout), 32'd0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
